// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM transaction sequencer: command, address, dummy and data phases,
// with chip select, SIO direction, slice counter and slice-buffer push strobe.
module idli_sqi_ctrl_m #(
  parameter logic [7:0]  CMD_RD       = 8'h03,
  parameter logic [7:0]  CMD_WR       = 8'h02,
  parameter int unsigned DUMMY_CYCLES = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_ctrl_vld,
  output logic        o_ctrl_rdy,
  input  logic        i_ctrl_wr,
  input  logic [15:0] i_ctrl_addr,
  input  logic [3:0]  i_ctrl_len,
  input  logic        i_ctrl_abort,
  output logic        o_ctrl_done,
  input  logic [3:0]  i_wr_slice,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_oe,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio,
  output logic [1:0]  o_sqi_ctr,
  output logic        o_buf_push,
  output logic [3:0]  o_buf_slice,
  input  logic [3:0]  i_buf_slice
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StEnd
  } state_e;

  state_e      state_q;
  logic        wr_q;
  logic [4:0]  words_q;
  logic [7:0]  phase_q;
  logic [27:0] sh_q;
  logic        cs_n_q;
  logic        oe_q;
  logic [3:0]  sio_q;
  logic [1:0]  ctr_q;
  logic        push_q;
  logic        done_q;
  logic        rdy_q;

  logic       active;
  logic       last_beat;
  logic       to_end;
  logic [7:0] cmd_sel;

  assign active    = (state_q == StCmd) || (state_q == StAddr) ||
                     (state_q == StDummy) || (state_q == StData);
  assign last_beat = (state_q == StData) && (ctr_q == 2'd3) && (words_q == 5'd1);
  assign to_end    = (active && i_ctrl_abort) || last_beat;
  assign cmd_sel   = i_ctrl_wr ? CMD_WR : CMD_RD;

  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      words_q <= 5'd0;
      phase_q <= 8'd0;
      sh_q    <= 28'd0;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      sio_q   <= 4'd0;
      ctr_q   <= 2'd0;
      push_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (to_end) begin
      // Abort and natural completion share one END cycle, so done pulses once.
      state_q <= StEnd;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      sio_q   <= 4'd0;
      ctr_q   <= 2'd0;
      push_q  <= 1'b0;
      done_q  <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_ctrl_vld) begin
            state_q <= StCmd;
            wr_q    <= i_ctrl_wr;
            words_q <= (i_ctrl_len == 4'd0) ? 5'd16 : {1'b0, i_ctrl_len};
            phase_q <= 8'd0;
            // Remaining nibbles after cmd[7:4]: cmd[3:0] then 24b byte address.
            sh_q    <= {cmd_sel[3:0], 7'b0, i_ctrl_addr, 1'b0};
            sio_q   <= cmd_sel[7:4];
            cs_n_q  <= 1'b0;
            oe_q    <= 1'b1;
            rdy_q   <= 1'b0;
          end
        end
        StCmd: begin
          sio_q <= sh_q[27:24];
          sh_q  <= {sh_q[23:0], 4'd0};
          if (phase_q == 8'd1) begin
            state_q <= StAddr;
            phase_q <= 8'd0;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        StAddr: begin
          if (phase_q == 8'd5) begin
            phase_q <= 8'd0;
            sio_q   <= 4'd0;
            if (wr_q) begin
              state_q <= StData;
              push_q  <= 1'b1;
              ctr_q   <= 2'd0;
              oe_q    <= 1'b1;
            end else begin
              state_q <= StDummy;
              oe_q    <= 1'b0;
            end
          end else begin
            sio_q   <= sh_q[27:24];
            sh_q    <= {sh_q[23:0], 4'd0};
            phase_q <= phase_q + 8'd1;
          end
        end
        StDummy: begin
          if (phase_q == 8'(DUMMY_CYCLES - 1)) begin
            state_q <= StData;
            phase_q <= 8'd0;
            push_q  <= 1'b1;
            ctr_q   <= 2'd0;
            oe_q    <= 1'b0;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        StData: begin
          ctr_q <= ctr_q + 2'd1;
          if (ctr_q == 2'd3) begin
            words_q <= words_q - 5'd1;
          end
        end
        StEnd: begin
          state_q <= StIdle;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_ctrl_rdy  = rdy_q;
  assign o_ctrl_done = done_q;
  assign o_sqi_cs_n  = cs_n_q;
  assign o_sqi_oe    = oe_q;
  // Write data bypasses the SIO register so the buffer output goes straight to the pins.
  assign o_sqi_sio   = ((state_q == StData) && wr_q) ? i_buf_slice : sio_q;
  assign o_sqi_ctr   = ctr_q;
  assign o_buf_push  = push_q;
  assign o_buf_slice = wr_q ? i_wr_slice : i_sqi_sio;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m: vector table of whole transactions plus
// hand sequences for abort, reset and back-to-back requests.
module tb_idli_sqi_ctrl_m;

  logic        clk;
  logic        rst;
  logic        vld;
  logic        rdy;
  logic        wr;
  logic [15:0] addr;
  logic [3:0]  len;
  logic        abort;
  logic        done;
  logic [3:0]  wr_sl;
  logic        cs_n;
  logic        oe;
  logic [3:0]  sio_o;
  logic [3:0]  sqi_in;
  logic [1:0]  ctr;
  logic        push;
  logic [3:0]  bslice;
  logic [3:0]  buf_in;

  int n_checks = 0;
  int n_errors = 0;

  idli_sqi_ctrl_m #(
    .CMD_RD      (8'h03),
    .CMD_WR      (8'h02),
    .DUMMY_CYCLES(2)
  ) dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst   (rst),
    .i_ctrl_vld  (vld),
    .o_ctrl_rdy  (rdy),
    .i_ctrl_wr   (wr),
    .i_ctrl_addr (addr),
    .i_ctrl_len  (len),
    .i_ctrl_abort(abort),
    .o_ctrl_done (done),
    .i_wr_slice  (wr_sl),
    .o_sqi_cs_n  (cs_n),
    .o_sqi_oe    (oe),
    .o_sqi_sio   (sio_o),
    .i_sqi_sio   (sqi_in),
    .o_sqi_ctr   (ctr),
    .o_buf_push  (push),
    .o_buf_slice (bslice),
    .i_buf_slice (buf_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  len;
    logic [31:0] nib;   // cmd + address nibbles, first one in bits [31:28]
    int          low;   // cycles with cs_n low
    int          push;  // cycles with push high
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int low = 0;
    int pushes = 0;
    int bad_ctr = 0;
    int bad_oe = 0;
    int bad_data = 0;
    int bad_done = 0;
    logic [31:0] nib = 32'd0;
    @(negedge clk);
    check("rdy_idle", {31'd0, rdy}, 32'd1);
    vld = 1'b1; wr = v.wr; addr = v.addr; len = v.len;
    @(posedge clk);
    #1 vld = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      sqi_in = 4'(c * 5 + 1);
      buf_in = 4'(c * 3 + 2);
      wr_sl  = 4'(c + 7);
      #1;
      if (cs_n) break;
      if (low < 8) begin
        nib = {nib[27:0], sio_o};
        if (!oe || push || ctr != 2'd0) bad_oe++;
      end else if (push) begin
        if (ctr != 2'(pushes)) bad_ctr++;
        if (oe != v.wr) bad_oe++;
        if (v.wr ? (sio_o != buf_in || bslice != wr_sl) : (bslice != sqi_in)) bad_data++;
        pushes++;
      end else begin
        if (oe || ctr != 2'd0 || sio_o != 4'd0) bad_oe++;
      end
      if (done) bad_done++;
      low++;
    end
    check("txn_nibbles", nib, v.nib);
    check("txn_cs_low", 32'(low), 32'(v.low));
    check("txn_pushes", 32'(pushes), 32'(v.push));
    check("txn_ctr_seq", 32'(bad_ctr), 32'd0);
    check("txn_oe", 32'(bad_oe), 32'd0);
    check("txn_data_path", 32'(bad_data), 32'd0);
    check("txn_early_done", 32'(bad_done), 32'd0);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_rdy", {31'd0, rdy}, 32'd0);
    check("end_push_oe", {30'd0, push, oe}, 32'd0);
    @(negedge clk);
    #1;
    check("idle_done_low", {31'd0, done}, 32'd0);
    check("idle_rdy", {31'd0, rdy}, 32'd1);
  endtask

  initial begin
    int high_cnt;
    int dones;
    int seen;

    vecs[0] = '{wr: 1'b1, addr: 16'h1234, len: 4'd1, nib: 32'h0200_2468, low: 12, push: 4};
    vecs[1] = '{wr: 1'b0, addr: 16'hABCD, len: 4'd2, nib: 32'h0301_579A, low: 18, push: 8};
    vecs[2] = '{wr: 1'b0, addr: 16'hFFFF, len: 4'd0, nib: 32'h0301_FFFE, low: 74, push: 64};
    vecs[3] = '{wr: 1'b1, addr: 16'h8000, len: 4'd3, nib: 32'h0201_0000, low: 20, push: 12};

    rst = 1'b1; vld = 1'b0; wr = 1'b0; addr = 16'd0; len = 4'd0; abort = 1'b0;
    wr_sl = 4'd0; sqi_in = 4'd0; buf_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_oe_push_done", {29'd0, oe, push, done}, 32'd0);
    check("rst_ctr_sio", {26'd0, ctr, sio_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Abort on the third ADDR cycle.
    @(negedge clk);
    vld = 1'b1; wr = 1'b0; addr = 16'h0055; len = 4'd1;
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort_pre_cs", {30'd0, cs_n, push}, 32'd0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_end_cs_done", {30'd0, cs_n, done}, 32'h3);
    check("abort_end_push_rdy", {30'd0, push, rdy}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_idle", {29'd0, rdy, done, cs_n}, 32'h5);

    // Abort while idle has no effect.
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_idle_ignored", {29'd0, rdy, done, cs_n}, 32'h5);

    // Abort coincident with the final DATA beat of a 1-word read.
    @(negedge clk);
    vld = 1'b1; wr = 1'b0; addr = 16'h0000; len = 4'd1;
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    check("last_beat_ctr_push", {29'd0, ctr, push}, 32'h7);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("last_beat_abort_end", {30'd0, cs_n, done}, 32'h3);
    @(posedge clk);
    #1;
    check("last_beat_single_done", {30'd0, rdy, done}, 32'h2);

    // Reset mid-DATA of a write.
    @(negedge clk);
    vld = 1'b1; wr = 1'b1; addr = 16'h0042; len = 4'd2;
    @(posedge clk);
    #1 vld = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("rst_mid_pre_push", {31'd0, push}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_mid_oe_push_done", {29'd0, oe, push, done}, 32'd0);
    check("rst_mid_ctr", {30'd0, ctr}, 32'd0);
    check("rst_mid_rdy", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_no_done", {31'd0, done}, 32'd0);
    run_txn(vecs[0]);

    // vld held high across two back-to-back requests.
    @(negedge clk);
    vld = 1'b1; wr = 1'b0; addr = 16'h0000; len = 4'd1;
    @(posedge clk);
    #1;
    check("b2b_first_accept", {31'd0, cs_n}, 32'd0);
    high_cnt = 0; dones = 0; seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (cs_n) begin
        high_cnt++;
        if (done) dones++;
      end else if (high_cnt > 0) begin
        seen = 1;
        break;
      end
    end
    vld = 1'b0;
    check("b2b_second_accept", 32'(seen), 32'd1);
    check("b2b_cs_high_gap", 32'(high_cnt), 32'd2);
    check("b2b_done_count", 32'(dones), 32'd1);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("b2b_second_done", 32'(seen), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
